truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper_if.sv | 38 +++
 rtl/truth_table_sweeper.sv | 108 ++++++++++
 2 files changed

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - handshake/bus bundle between a sweep controller and its user
// Purpose: groups the sweep request, the datapath drive/sense pins and the
//          sweep status so the controller has a single bus port.
// Signals:
//   start    - sweep request (user -> sweeper)
//   expected - expected datapath output, bit m for minterm m (user -> sweeper)
//   s_in     - output of the 2-input datapath under test (user -> sweeper)
//   a_out    - datapath operand a, = m_idx[1] (sweeper -> user)
//   b_out    - datapath operand b, = m_idx[0] (sweeper -> user)
//   m_idx    - current minterm index (sweeper -> user)
//   busy     - high while driving/sampling (sweeper -> user)
//   done     - one-cycle completion pulse (sweeper -> user)
//   result   - captured s_in, bit m for minterm m (sweeper -> user)
//   err_cnt  - mismatch count 0..4 (sweeper -> user)
//   pass     - err_cnt == 0 after completion (sweeper -> user)
interface truth_table_sweeper_if;
  logic       start;
  logic [3:0] expected;
  logic       s_in;
  logic       a_out;
  logic       b_out;
  logic [1:0] m_idx;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [2:0] err_cnt;
  logic       pass;

  modport master (
    output start, expected, s_in,
    input  a_out, b_out, m_idx, busy, done, result, err_cnt, pass
  );

  modport slave (
    input  start, expected, s_in,
    output a_out, b_out, m_idx, busy, done, result, err_cnt, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table checker for a 2-input combinational datapath
// Purpose: on start, walks minterms 0..3, driving a/b for one settle cycle
//          (DRIVE) then capturing the datapath output (SAMPLE), comparing
//          each capture against a latched expected table.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - truth_table_sweeper_if.slave (start/expected/s_in in;
//           a_out/b_out/m_idx/busy/done/result/err_cnt/pass out)
// Build option: MISMATCH_STOP_EN - when defined, the first mismatching
//   capture ends the sweep with m_idx left on the failing minterm.
module truth_table_sweeper (
  input  logic                        clk,
  input  logic                        rst_n,
  truth_table_sweeper_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] m_q;
  logic [3:0] exp_q;
  logic [3:0] res_q;
  logic [2:0] err_q;
  logic       pass_q;

  logic       mismatch;
  logic       last_minterm;
  logic       accept;

  assign mismatch     = (bus.s_in != exp_q[m_q]);
  assign last_minterm = (m_q == 2'd3);
  assign accept       = (state_q == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = DRIVE;
      DRIVE:  state_d = SAMPLE;
      SAMPLE: begin
`ifdef MISMATCH_STOP_EN
        if (mismatch || last_minterm) state_d = DONE;
        else                          state_d = DRIVE;
`else
        if (last_minterm) state_d = DONE;
        else              state_d = DRIVE;
`endif
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers. All of them hold through IDLE so the outcome of the
  // last sweep stays readable until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= 2'd0;
      exp_q  <= 4'd0;
      res_q  <= 4'd0;
      err_q  <= 3'd0;
      pass_q <= 1'b0;
    end else if (accept) begin
      m_q    <= 2'd0;
      exp_q  <= bus.expected;
      res_q  <= 4'd0;
      err_q  <= 3'd0;
      pass_q <= 1'b0;
    end else if (state_q == SAMPLE) begin
      res_q[m_q] <= bus.s_in;
      // Saturate at 4: only four minterms exist, so this guard never trips
      // in normal use but keeps the counter from wrapping regardless.
      if (mismatch && (err_q != 3'd4)) begin
        err_q <= err_q + 3'd1;
      end
      // Advance only when another DRIVE follows; on the way to DONE the index
      // stays on the last visited (or failing) minterm.
      if (state_d == DRIVE) begin
        m_q <= m_q + 2'd1;
      end
    end else if (state_q == DONE) begin
      pass_q <= (err_q == 3'd0);
    end
  end

  assign bus.a_out   = m_q[1];
  assign bus.b_out   = m_q[0];
  assign bus.m_idx   = m_q;
  assign bus.busy    = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done    = (state_q == DONE);
  assign bus.result  = res_q;
  assign bus.err_cnt = err_q;
  assign bus.pass    = pass_q;

endmodule
